// File: rtl/spi_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_pkg
// Brief    : Opcode constants and FSM state type for the SPI LED controller.
// Revision : 1.0 - initial release
// ============================================================================
package spi_led_pkg;

    // Opcode nibble, decoded on cmd[7:4]
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_SET    = 4'h1;
    localparam logic [3:0] OP_DUTY   = 4'h2;
    localparam logic [3:0] OP_READ   = 4'h3;
    localparam logic [3:0] OP_TOGGLE = 4'h5;

    // Sub-opcodes of OP_READ, decoded on cmd[3:0]
    localparam logic [3:0] READ_ID     = 4'h0;
    localparam logic [3:0] READ_STATUS = 4'h1;

    // Decoder state: expecting an opcode, or the duty operand of OP_DUTY
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_OPERAND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm
// Brief    : Free-running PWM counter and per-LED duty comparators with
//            registered, mask-gated LED outputs.
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm #(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LEDS-1:0]           mask,
    input  logic [NUM_LEDS*PWM_WIDTH-1:0] duty,
    output logic [NUM_LEDS-1:0]           led
);

    logic [PWM_WIDTH-1:0] pwm_cnt_q;
    logic [PWM_WIDTH-1:0] pwm_cnt_d;
    logic [NUM_LEDS-1:0]  led_q;
    logic [NUM_LEDS-1:0]  led_d;

    // Counter wraps naturally; LED is on while the counter is below its duty
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
        led_d     = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = mask[i] && (pwm_cnt_q < duty[i*PWM_WIDTH +: PWM_WIDTH]);
        end
    end

    // Counter and LED output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule
`default_nettype wire

// File: rtl/spi_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_ctrl
// Brief    : Decodes SPI command bytes into an LED mask and per-LED duty,
//            keeps a saturating error count and the SPI response byte, and
//            drives the LEDs through led_pwm.
// Revision : 1.0 - initial release
// ============================================================================
module spi_led_ctrl
    import spi_led_pkg::*;
#(
    parameter int          NUM_LEDS  = 4,
    parameter int          PWM_WIDTH = 8,
    parameter logic [7:0]  ID_BYTE   = 8'hA8,
    parameter int          ERR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          cmd,
    input  logic                cmd_valid,
    input  logic                frame_active,
    output logic [7:0]          response,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy
);

    state_t                state_q, state_d;
    logic [NUM_LEDS-1:0]   mask_q, mask_d;
    logic [3:0]            idx_q, idx_d;
    logic [PWM_WIDTH-1:0]  duty_q [NUM_LEDS];
    logic [PWM_WIDTH-1:0]  duty_d [NUM_LEDS];
    logic [7:0]            response_q, response_d;
    logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_inc;

    logic [15:0]           x_ext;
    logic [15:0]           mask_ext;
    logic [15:0]           err_ext;
    logic [NUM_LEDS-1:0]   x_mask;
    logic [NUM_LEDS*PWM_WIDTH-1:0] duty_vec;

    // Operand nibble widened/truncated to the mask width; status fields fit 4 bits
    assign x_ext    = {12'h000, cmd[3:0]};
    assign x_mask   = x_ext[NUM_LEDS-1:0];
    assign mask_ext = 16'(mask_q);
    assign err_ext  = 16'(err_cnt_q);

    // Opcode decode, operand capture and next-state logic
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        duty_d     = duty_q;
        response_d = response_q;
        err_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd[7:4])
                        OP_NOP: begin
                            if (cmd[3:0] != 4'h0) err_inc = 1'b1;
                        end
                        OP_SET: begin
                            mask_d = x_mask;
                        end
                        OP_TOGGLE: begin
                            mask_d = mask_q ^ x_mask;
                        end
                        OP_DUTY: begin
                            if ({1'b0, cmd[3:0]} < 5'(NUM_LEDS)) begin
                                idx_d   = cmd[3:0];
                                state_d = ST_OPERAND;
                            end else begin
                                err_inc = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (cmd[3:0] == READ_ID) begin
                                response_d = ID_BYTE;
                            end else if (cmd[3:0] == READ_STATUS) begin
                                response_d = {mask_ext[3:0], err_ext[3:0]};
                            end else begin
                                err_inc = 1'b1;
                            end
                        end
                        default: begin
                            err_inc = 1'b1;
                        end
                    endcase
                end
            end
            ST_OPERAND: begin
                // A strobe wins over a frame ending on the same cycle
                if (cmd_valid) begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (idx_q == 4'(i)) duty_d[i] = PWM_WIDTH'(cmd);
                    end
                    state_d = ST_IDLE;
                end else if (!frame_active) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {ERR_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
        end
    end

    // Control and data registers; reset discards any pending operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            response_q <= ID_BYTE;
            err_cnt_q  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '1;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            response_q <= response_d;
            err_cnt_q  <= err_cnt_d;
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= duty_d[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_LEDS; g++) begin : g_duty_pack
            assign duty_vec[g*PWM_WIDTH +: PWM_WIDTH] = duty_q[g];
        end
    endgenerate

    led_pwm #(
        .NUM_LEDS  (NUM_LEDS),
        .PWM_WIDTH (PWM_WIDTH)
    ) u_led_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .mask  (mask_q),
        .duty  (duty_vec),
        .led   (led)
    );

    assign response = response_q;
    assign busy     = (state_q == ST_OPERAND);

endmodule
`default_nettype wire

// File: tb/tb_spi_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_led_ctrl
// Brief    : Directed self-checking bench for spi_led_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_led_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_active;
    logic [7:0] response;
    logic [3:0] led;
    logic       busy;

    int checks;
    int errors;
    int on_cnt [4];

    spi_led_ctrl #(
        .NUM_LEDS  (4),
        .PWM_WIDTH (8),
        .ID_BYTE   (8'hA8),
        .ERR_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .frame_active (frame_active),
        .response     (response),
        .led          (led),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for exactly one cycle; called and returns on a negedge
    task automatic send(input logic [7:0] b);
        cmd       = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 8'h00;
    endtask

    // Let the LED register catch up, then count on-cycles over one PWM period
    task automatic count_leds();
        @(negedge clk);
        for (int i = 0; i < 4; i++) on_cnt[i] = 0;
        for (int c = 0; c < 256; c++) begin
            for (int i = 0; i < 4; i++) on_cnt[i] += int'(led[i]);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int led_on;
        do_reset();
        checks++;
        if (led !== 4'h0) begin
            errors++; $display("FAIL reset_led: got %h expected 0", led);
        end
        checks++;
        if (response !== 8'hA8) begin
            errors++; $display("FAIL reset_response: got %h expected a8", response);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        led_on = 0;
        for (int c = 0; c < 300; c++) begin
            if (led !== 4'h0) led_on++;
            @(negedge clk);
        end
        checks++;
        if (led_on != 0) begin
            errors++; $display("FAIL idle_led: %0d cycles with led on, expected 0", led_on);
        end
        send(8'h31);
        checks++;
        if (response !== 8'h00) begin
            errors++; $display("FAIL reset_status: got %h expected 00", response);
        end
    endtask

    task automatic test_mask();
        send(8'h1F);
        count_leds();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (on_cnt[i] != 255) begin
                errors++; $display("FAIL mask_all led%0d: got %0d on-cycles expected 255", i, on_cnt[i]);
            end
        end
        send(8'h53);
        count_leds();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (on_cnt[i] != ((i >= 2) ? 255 : 0)) begin
                errors++; $display("FAIL mask_toggle led%0d: got %0d on-cycles expected %0d",
                                   i, on_cnt[i], (i >= 2) ? 255 : 0);
            end
        end
    endtask

    task automatic test_duty();
        send(8'h1F);
        send(8'h21);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL duty_busy_high: got %b expected 1", busy);
        end
        send(8'h40);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL duty_busy_low: got %b expected 0", busy);
        end
        send(8'h22);
        send(8'h00);
        count_leds();
        checks++;
        if (on_cnt[0] != 255) begin
            errors++; $display("FAIL duty_led0: got %0d expected 255", on_cnt[0]);
        end
        checks++;
        if (on_cnt[1] != 64) begin
            errors++; $display("FAIL duty_led1: got %0d expected 64", on_cnt[1]);
        end
        checks++;
        if (on_cnt[2] != 0) begin
            errors++; $display("FAIL duty_led2: got %0d expected 0", on_cnt[2]);
        end
        checks++;
        if (on_cnt[3] != 255) begin
            errors++; $display("FAIL duty_led3: got %0d expected 255", on_cnt[3]);
        end
    endtask

    task automatic test_status();
        send(8'h15);
        send(8'h31);
        checks++;
        if (response !== 8'h50) begin
            errors++; $display("FAIL status_clean: got %h expected 50", response);
        end
        send(8'hFF);
        send(8'h27);
        send(8'h31);
        checks++;
        if (response !== 8'h52) begin
            errors++; $display("FAIL status_two_err: got %h expected 52", response);
        end
        send(8'h30);
        checks++;
        if (response !== 8'hA8) begin
            errors++; $display("FAIL read_id: got %h expected a8", response);
        end
    endtask

    task automatic test_abort();
        send(8'h1F);
        send(8'h23);
        frame_active = 1'b0;
        @(negedge clk);
        frame_active = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b expected 0", busy);
        end
        send(8'h31);
        checks++;
        if (response !== 8'hF3) begin
            errors++; $display("FAIL abort_err: got %h expected f3", response);
        end
        count_leds();
        checks++;
        if (on_cnt[3] != 255) begin
            errors++; $display("FAIL abort_duty3: got %0d expected 255", on_cnt[3]);
        end
        send(8'h23);
        frame_active = 1'b0;
        send(8'h80);
        frame_active = 1'b1;
        send(8'h31);
        checks++;
        if (response !== 8'hF3) begin
            errors++; $display("FAIL strobe_wins_err: got %h expected f3", response);
        end
        count_leds();
        checks++;
        if (on_cnt[3] != 128) begin
            errors++; $display("FAIL strobe_wins_duty3: got %0d expected 128", on_cnt[3]);
        end
    endtask

    task automatic test_saturate_and_reset();
        for (int k = 0; k < 20; k++) send(8'h60);
        send(8'h31);
        checks++;
        if (response !== 8'hFF) begin
            errors++; $display("FAIL err_saturate: got %h expected ff", response);
        end
        send(8'h20);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || led !== 4'h0 || response !== 8'hA8) begin
            errors++; $display("FAIL async_reset: got busy=%b led=%h resp=%h expected 0/0/a8",
                               busy, led, response);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h31);
        checks++;
        if (response !== 8'h00) begin
            errors++; $display("FAIL reset_clears_err: got %h expected 00", response);
        end
    endtask

    task automatic test_back_to_back();
        send(8'h12);
        send(8'h31);
        checks++;
        if (response !== 8'h20) begin
            errors++; $display("FAIL back_to_back: got %h expected 20", response);
        end
        count_leds();
        checks++;
        if (on_cnt[1] != 255 || on_cnt[0] != 0 || on_cnt[2] != 0 || on_cnt[3] != 0) begin
            errors++; $display("FAIL reset_duty: got %0d/%0d/%0d/%0d expected 0/255/0/0",
                               on_cnt[0], on_cnt[1], on_cnt[2], on_cnt[3]);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        cmd          = 8'h00;
        cmd_valid    = 1'b0;
        frame_active = 1'b1;
        @(negedge clk);
        test_reset();
        test_mask();
        test_duty();
        test_status();
        test_abort();
        test_saturate_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_led_ctrl.md
# spi_led_ctrl

Command decoder and LED scheduler that sits between the SPI slave's byte output and the board LEDs. It interprets each received byte as an opcode, or as the operand of the preceding opcode, and maintains an LED enable mask and a per-LED PWM duty. It drives the LEDs through a free-running PWM and supplies the SPI response byte for the next transfer. It replaces direct wiring of the last command byte onto the LED pins.

## Interface
- NUM_LEDS, 4: LEDs driven; 1..15.
- PWM_WIDTH, 8: PWM counter and duty width.
- ID_BYTE, 8'hA8: default/identity response.
- ERR_WIDTH, 4: saturating error counter width.

- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- cmd  in  8  received byte from the SPI slave
- cmd_valid  in  1  one-cycle strobe; cmd is valid on this cycle
- frame_active  in  1  high while SPI slave select is asserted (already synchronised to clk)
- response  out  8  byte the slave shifts out on the next transfer
- led  out  NUM_LEDS  LED drive, active high
- busy  out  1  high while waiting for an operand byte

## Operation
- FSM states:
  - IDLE: the next strobed byte is an opcode.
  - OPERAND: the next strobed byte is a duty value for the latched LED index.
- Opcodes, decoded on cmd[7:4] with X = cmd[3:0]:
  - 0x00: NOP.
  - 0x1X: mask <= X[NUM_LEDS-1:0].
  - 0x5X: mask <= mask ^ X[NUM_LEDS-1:0].
  - 0x2X: if X < NUM_LEDS, latch index X and go to OPERAND; otherwise it is an error and the FSM stays in IDLE.
  - 0x30: response <= ID_BYTE.
  - 0x31: response <= {mask zero-extended to 4 bits, err_cnt[3:0]}. For ERR_WIDTH < 4, err_cnt is zero-extended; for ERR_WIDTH > 4, the low 4 bits are used.
  - Any other byte in IDLE is an error.
- OPERAND + cmd_valid: duty[index] <= cmd, then go to IDLE.
- OPERAND, frame_active low and no cmd_valid on that cycle: abort. This counts as an error, duty is unchanged, and the FSM returns to IDLE.
- cmd_valid takes precedence over frame_active on the same cycle.
- Error handling: err_cnt increments and saturates at 2^ERR_WIDTH−1. It clears only on reset.
- response holds its value until a 0x30 or 0x31 opcode changes it.
- PWM: pwm_cnt is a free-running PWM_WIDTH-bit counter that wraps from all-ones to 0.
  - led[i] <= mask[i] && (pwm_cnt < duty[i]).
  - Duty 0 means always off. Duty all-ones means on for (2^PWM_WIDTH−1) of every 2^PWM_WIDTH cycles.
- busy = (state == OPERAND).

## Timing
- Reset values:
  - state IDLE, busy 0
  - mask 0, led 0
  - every duty all-ones
  - err_cnt 0, pwm_cnt 0
  - response ID_BYTE
- All outputs are registered.
- Latencies:
  - mask, duty, state, response and err_cnt update on the clk edge following the cmd_valid cycle (1-cycle latency).
  - led reflects the new mask/duty one cycle after that (2 cycles from cmd_valid).
- cmd_valid is assumed to be a single-cycle pulse. Back-to-back strobes on consecutive cycles must each be processed.
- Reset asserted mid-operand returns to IDLE immediately, asynchronously. A pending operand is discarded and no error is counted.

## Structure
- Package spi_led_pkg holds:
  - opcode nibble constants OP_NOP=0, OP_SET=1, OP_DUTY=2, OP_READ=3, OP_TOGGLE=5
  - sub-opcodes READ_ID=0, READ_STATUS=1
  - the FSM state enum
- Sub-module led_pwm contains the free-running counter and the NUM_LEDS comparators with registered outputs. It takes mask and a packed duty vector as inputs.
- Decoder, FSM, error counter and response register stay in spi_led_ctrl.

## Test plan
- Reset, then idle for 300 cycles: led=0, response=8'hA8, busy=0, err_cnt=0.
- Send 0x1F, then run 256 cycles: every led high for 255 of 256 cycles. Send 0x53: led[3:2] stay active and led[1:0] become 0.
- With mask=0xF, send 0x21 then 0x40: busy is high between the two bytes. Over 256 cycles led[1] is high for exactly 64 and led[0] for 255. Send 0x22 then 0x00: led[2] is constant 0.
- Send 0x31 after mask=0x5 with no errors: response=8'h50. Send 0xFF, 0x27, then 0x31: response=8'h52.
- Send 0x23, then drop frame_active for 1 cycle with no strobe: busy falls, duty[3] is unchanged, err_cnt increments. Also strobe cmd_valid on the same cycle frame_active falls: the operand is accepted and no error is counted.
- Send 20 invalid bytes: err_cnt saturates at 15 and 0x31 returns 8'hXF. Assert rst_n low between 0x20 and its operand: the design returns to the reset state, busy=0, err_cnt=0.
